// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-level scene scheduler with fade ramps.
// State moves only on vsync frame ticks, so outputs change in blanking.
module scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_W      = 2,
  parameter int SCENE_FRAMES = 240,
  parameter int FADE_W       = 3,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               skip,
  input  logic               pause,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_count,
  output logic [SCENE_W-1:0] scene,
  output logic               scene_start,
  output logic [FADE_W-1:0]  fade,
  output logic [1:0]         state
);

  localparam logic [1:0] FADE_IN  = 2'd0;
  localparam logic [1:0] PLAY     = 2'd1;
  localparam logic [1:0] FADE_OUT = 2'd2;
  localparam logic [1:0] SWITCH   = 2'd3;

  localparam int DWELL_W =
    (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST =
    DWELL_W'(SCENE_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST =
    SCENE_W'(NUM_SCENES - 1);
  localparam logic [FADE_W-1:0] FADE_TOP =
    FADE_W'((1 << FADE_W) - 2);
  localparam logic [FADE_W-1:0] FADE_ONE = FADE_W'(1);

  logic               vsync_q;
  logic               skip_pending;
  logic [DWELL_W-1:0] dwell;
  logic               play_done;
  logic               consume;

  // A pending skip ends PLAY even while paused; the dwell limit does not.
  assign play_done = skip_pending |
                     (~pause & (dwell == DWELL_LAST));
  assign consume   = frame_tick & (state == PLAY) & play_done;

  // Follow vsync through reset so a line already low at release
  // is not mistaken for a falling edge.
  always_ff @(posedge clk) begin
    vsync_q <= vsync;
  end

  // Registered falling-edge detect on the active-low vsync.
  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= vsync_q & ~vsync;
  end

  // Skip requests wait for PLAY; one arriving as a skip is served is dropped.
  always_ff @(posedge clk) begin
    if (rst)          skip_pending <= 1'b0;
    else if (consume) skip_pending <= 1'b0;
    else if (skip)    skip_pending <= 1'b1;
  end

  // Frame counter, scene FSM and fade ramp, all stepped by the frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FADE_IN;
      scene       <= '0;
      fade        <= '0;
      frame_count <= '0;
      dwell       <= '0;
      scene_start <= 1'b0;
    end else begin
      scene_start <= 1'b0;
      if (frame_tick) begin
        frame_count <= frame_count + FRAME_W'(1);
        unique case (state)
          FADE_IN: begin
            fade <= fade + FADE_ONE;
            if (fade == FADE_TOP) begin
              state <= PLAY;
              dwell <= '0;
            end
          end
          PLAY: begin
            if (play_done) begin
              state <= FADE_OUT;
              dwell <= '0;
            end else if (!pause) begin
              dwell <= dwell + DWELL_W'(1);
            end
          end
          FADE_OUT: begin
            fade <= fade - FADE_ONE;
            if (fade == FADE_ONE) state <= SWITCH;
          end
          SWITCH: begin
            if (scene == SCENE_LAST) scene <= '0;
            else                     scene <= scene + SCENE_W'(1);
            scene_start <= 1'b1;
            state       <= FADE_IN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed and random checks of scene_sequencer
// against a frame-level reference model.
module tb_scene_sequencer;

  localparam int NS   = 3;
  localparam int SW   = 2;
  localparam int SF   = 4;
  localparam int FW   = 2;
  localparam int CW   = 6;
  localparam int FMAX = 3;

  localparam int PH_IN   = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_OUT  = 2;
  localparam int PH_SW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          skip;
  logic          pause;
  logic          frame_tick;
  logic [CW-1:0] frame_count;
  logic [SW-1:0] scene;
  logic          scene_start;
  logic [FW-1:0] fade;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  int m_frame, m_scene, m_fade, m_phase, m_dwell;
  bit m_pend, m_tick, m_start;
  bit m_vs = 1'b1;
  bit saw_start;

  int exp_fade[11]  = '{1, 2, 3, 3, 3, 3, 3, 2, 1, 0, 0};
  int exp_phase[11] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 0};

  always #5 clk = ~clk;

  scene_sequencer #(
    .NUM_SCENES  (NS),
    .SCENE_W     (SW),
    .SCENE_FRAMES(SF),
    .FADE_W      (FW),
    .FRAME_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .skip       (skip),
    .pause      (pause),
    .frame_tick (frame_tick),
    .frame_count(frame_count),
    .scene      (scene),
    .scene_start(scene_start),
    .fade       (fade),
    .state      (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one call per clock edge, frame rules applied on a tick.
  task automatic model_edge();
    bit ev;
    bit used;
    ev      = m_tick;
    used    = 1'b0;
    m_start = 1'b0;
    if (rst) begin
      m_frame = 0;
      m_scene = 0;
      m_fade  = 0;
      m_phase = PH_IN;
      m_dwell = 0;
      m_pend  = 1'b0;
      m_tick  = 1'b0;
    end else begin
      if (ev) begin
        m_frame = (m_frame + 1) % (1 << CW);
        case (m_phase)
          PH_IN: begin
            m_fade = m_fade + 1;
            if (m_fade == FMAX) begin
              m_phase = PH_PLAY;
              m_dwell = 0;
            end
          end
          PH_PLAY: begin
            if (m_pend || (!pause && m_dwell == SF - 1)) begin
              m_phase = PH_OUT;
              m_dwell = 0;
              used    = 1'b1;
            end else if (!pause) begin
              m_dwell = m_dwell + 1;
            end
          end
          PH_OUT: begin
            m_fade = m_fade - 1;
            if (m_fade == 0) m_phase = PH_SW;
          end
          default: begin
            m_scene = (m_scene + 1) % NS;
            m_start = 1'b1;
            m_phase = PH_IN;
          end
        endcase
      end
      if (used)      m_pend = 1'b0;
      else if (skip) m_pend = 1'b1;
      m_tick = m_vs & ~vsync;
    end
    m_vs = vsync;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("frame_tick", frame_tick, m_tick);
    chk("frame_count", frame_count, m_frame);
    chk("scene", scene, m_scene);
    chk("scene_start", scene_start, m_start);
    chk("fade", fade, m_fade);
    chk("state", state, m_phase);
    if (scene_start) saw_start = 1'b1;
  endtask

  // One 20-cycle frame: vsync low for lo cycles, optional skip pulse.
  task automatic run_frame(input int lo, input int skip_at, input bit pz);
    for (int c = 0; c < 20; c++) begin
      vsync = (c < lo) ? 1'b0 : 1'b1;
      skip  = (c == skip_at);
      pause = pz;
      step();
    end
    skip = 1'b0;
  endtask

  initial begin
    int nt;
    int np;
    int fc0;
    int diff;
    int lo;
    int sa;
    bit pz;

    rst   = 1'b1;
    vsync = 1'b0;
    skip  = 1'b0;
    pause = 1'b0;
    repeat (3) step();
    chk("rst_fade", fade, 0);
    chk("rst_state", state, PH_IN);
    chk("rst_scene", scene, 0);
    chk("rst_count", frame_count, 0);

    rst = 1'b0;
    nt  = 0;
    repeat (4) begin
      step();
      nt += int'(frame_tick);
    end
    chk("release_low_no_tick", nt, 0);

    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
    chk("tick_latency", frame_tick, 1);
    chk("count_pre_update", frame_count, 0);
    step();
    chk("tick_one_cycle", frame_tick, 0);
    chk("count_first", frame_count, 1);
    chk("fade_tick1", fade, exp_fade[0]);
    vsync = 1'b1;
    repeat (18) step();

    for (int i = 1; i < 11; i++) begin
      saw_start = 1'b0;
      run_frame(2, -1, 1'b0);
      chk("seq_fade", fade, exp_fade[i]);
      chk("seq_state", state, exp_phase[i]);
    end
    chk("seq_scene1", scene, 1);
    chk("seq_start_seen", saw_start, 1);

    repeat (22) run_frame(2, -1, 1'b0);
    chk("wrap_scene0", scene, 0);
    chk("count_33", frame_count, 33);

    run_frame(2, -1, 1'b0);
    run_frame(2, 5, 1'b0);
    chk("skip_fade2", fade, 2);
    chk("skip_still_in", state, PH_IN);
    run_frame(2, -1, 1'b0);
    chk("skip_play", state, PH_PLAY);
    run_frame(2, 1, 1'b0);
    chk("skip_fade_out", state, PH_OUT);
    chk("skip_fade_hold", fade, 3);
    repeat (4) run_frame(2, -1, 1'b0);
    chk("skip_next_scene", scene, 1);
    np = 0;
    repeat (11) begin
      run_frame(2, -1, 1'b0);
      np += int'(state == PH_PLAY);
    end
    chk("absorbed_full_play", np, SF);
    chk("absorbed_scene2", scene, 2);

    repeat (4) run_frame(2, -1, 1'b0);
    chk("pause_pre_play", state, PH_PLAY);
    fc0 = int'(frame_count);
    repeat (10) run_frame(2, -1, 1'b1);
    diff = (int'(frame_count) - fc0 + (1 << CW)) % (1 << CW);
    chk("pause_hold", state, PH_PLAY);
    chk("pause_frames", diff, 10);
    chk("count_wrap", frame_count, 2);
    repeat (2) run_frame(2, -1, 1'b0);
    chk("pause_rest_play", state, PH_PLAY);
    run_frame(2, -1, 1'b0);
    chk("pause_out", state, PH_OUT);

    run_frame(2, -1, 1'b0);
    chk("mid_fade2", fade, 2);
    chk("mid_scene2", scene, 2);
    skip = 1'b1;
    step();
    skip = 1'b0;
    rst  = 1'b1;
    step();
    chk("mid_rst_fade", fade, 0);
    chk("mid_rst_state", state, PH_IN);
    chk("mid_rst_scene", scene, 0);
    chk("mid_rst_count", frame_count, 0);
    chk("mid_rst_tick", frame_tick, 0);
    rst = 1'b0;
    repeat (3) step();
    np = 0;
    repeat (11) begin
      run_frame(2, -1, 1'b0);
      np += int'(state == PH_PLAY);
    end
    chk("post_rst_play", np, SF);
    chk("post_rst_scene1", scene, 1);

    for (int f = 0; f < 150; f++) begin
      lo = int'($urandom_range(1, 4));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1;
      pz = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run_frame(lo, sa, pz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
